// File: rtl/bulls_cows_fsm.sv
// Two-player Bulls and Cows game controller: captures secrets, alternates
// guesses, scores bulls/cows and keeps per-player round wins.
module bulls_cows_fsm (
  input  logic        clock,
  input  logic        reset,
  input  logic        confirm,
  input  logic [15:0] SW,
  output logic [2:0]  game_state,
  output logic [2:0]  bull_count,
  output logic [2:0]  cow_count,
  output logic        guess_confirmed,
  output logic [7:0]  J1_points,
  output logic [7:0]  J2_points,
  output logic        winner,
  output logic        error
);

  typedef enum logic [2:0] {
    J1_SETUP = 3'b000,
    J2_SETUP = 3'b001,
    J1_GUESS = 3'b010,
    J2_GUESS = 3'b011,
    END_GAME = 3'b111
  } state_t;

  state_t      state;
  logic        conf_q;
  logic        press;
  logic [15:0] secret1;
  logic [15:0] secret2;
  logic [15:0] target;
  logic [3:0]  dig [4];
  logic [3:0]  sec [4];
  logic        valid;
  logic [2:0]  bulls;
  logic [2:0]  cows;

  assign press      = confirm & ~conf_q;
  assign game_state = state;

  // J1 guesses the secret entered by J2 and vice versa
  always_comb begin
    target = (state == J1_GUESS) ? secret2 : secret1;
    valid  = 1'b1;
    bulls  = 3'd0;
    cows   = 3'd0;
    for (int i = 0; i < 4; i++) begin
      dig[i] = SW[15-4*i -: 4];
      sec[i] = target[15-4*i -: 4];
    end
    for (int i = 0; i < 4; i++) begin
      if (dig[i] > 4'd9) valid = 1'b0;
      for (int j = i + 1; j < 4; j++)
        if (dig[i] == dig[j]) valid = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (dig[i] == sec[j]) begin
          if (i == j) bulls = bulls + 3'd1;
          else        cows  = cows + 3'd1;
        end
  end

  // conf_q is held high during reset so a button already down at release is ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= J1_SETUP;
      conf_q          <= 1'b1;
      secret1         <= 16'h0000;
      secret2         <= 16'h0000;
      bull_count      <= 3'd0;
      cow_count       <= 3'd0;
      guess_confirmed <= 1'b0;
      J1_points       <= 8'd0;
      J2_points       <= 8'd0;
      winner          <= 1'b0;
      error           <= 1'b0;
    end else begin
      conf_q <= confirm;
      error  <= 1'b0;
      if (press) begin
        case (state)
          J1_SETUP: begin
            if (valid) begin
              secret1 <= SW;
              state   <= J2_SETUP;
            end else begin
              error <= 1'b1;
            end
          end
          J2_SETUP: begin
            if (valid) begin
              secret2 <= SW;
              state   <= J1_GUESS;
            end else begin
              error <= 1'b1;
            end
          end
          J1_GUESS, J2_GUESS: begin
            if (guess_confirmed) begin
              guess_confirmed <= 1'b0;
              bull_count      <= 3'd0;
              cow_count       <= 3'd0;
              state           <= (state == J1_GUESS) ? J2_GUESS : J1_GUESS;
            end else if (!valid) begin
              error <= 1'b1;
            end else begin
              bull_count <= bulls;
              cow_count  <= cows;
              if (bulls == 3'd4) begin
                winner <= (state == J2_GUESS);
                state  <= END_GAME;
                if (state == J1_GUESS) begin
                  if (J1_points != 8'hFF) J1_points <= J1_points + 8'd1;
                end else begin
                  if (J2_points != 8'hFF) J2_points <= J2_points + 8'd1;
                end
              end else begin
                guess_confirmed <= 1'b1;
              end
            end
          end
          END_GAME: begin
            state      <= J1_SETUP;
            secret1    <= 16'h0000;
            secret2    <= 16'h0000;
            bull_count <= 3'd0;
            cow_count  <= 3'd0;
            winner     <= 1'b0;
          end
          default: state <= J1_SETUP;
        endcase
      end else if (state != J1_SETUP && state != J2_SETUP &&
                   state != J1_GUESS && state != J2_GUESS && state != END_GAME) begin
        state <= J1_SETUP;
      end
    end
  end

endmodule

// File: tb/tb_bulls_cows_fsm.sv
// Self-checking bench for bulls_cows_fsm: directed plan plus randomized games
// scored by a digit-level reference model of the game rules.
module tb_bulls_cows_fsm;

  logic        clock;
  logic        reset;
  logic        confirm;
  logic [15:0] SW;
  logic [2:0]  game_state;
  logic [2:0]  bull_count;
  logic [2:0]  cow_count;
  logic        guess_confirmed;
  logic [7:0]  J1_points;
  logic [7:0]  J2_points;
  logic        winner;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model of the game
  int          m_state;
  logic [15:0] m_secret [2];
  int          m_bull, m_cow, m_p1, m_p2;
  bit          m_gc, m_winner, m_err;

  bulls_cows_fsm dut (
    .clock(clock), .reset(reset), .confirm(confirm), .SW(SW),
    .game_state(game_state), .bull_count(bull_count), .cow_count(cow_count),
    .guess_confirmed(guess_confirmed), .J1_points(J1_points), .J2_points(J2_points),
    .winner(winner), .error(error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int digit(input logic [15:0] v, input int i);
    return int'(v[15-4*i -: 4]);
  endfunction

  function automatic bit is_valid(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      if (digit(v, i) > 9) return 1'b0;
      for (int j = 0; j < i; j++)
        if (digit(v, i) == digit(v, j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] rand_valid();
    int d [10];
    logic [15:0] r;
    for (int i = 0; i < 10; i++) d[i] = i;
    for (int i = 0; i < 4; i++) begin
      int j = int'($urandom_range(9, i));
      int t = d[i];
      d[i] = d[j];
      d[j] = t;
    end
    r = {d[0][3:0], d[1][3:0], d[2][3:0], d[3][3:0]};
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_secret[0] = '0; m_secret[1] = '0;
    m_bull = 0; m_cow = 0; m_p1 = 0; m_p2 = 0;
    m_gc = 0; m_winner = 0; m_err = 0;
  endtask

  task automatic model_press(input logic [15:0] sw);
    m_err = 0;
    case (m_state)
      0, 1: begin
        if (is_valid(sw)) begin
          m_secret[m_state] = sw;
          m_state = m_state + 1;
        end else m_err = 1;
      end
      2, 3: begin
        int g = m_state - 2;
        if (m_gc) begin
          m_gc = 0; m_bull = 0; m_cow = 0;
          m_state = (m_state == 2) ? 3 : 2;
        end else if (!is_valid(sw)) begin
          m_err = 1;
        end else begin
          m_bull = 0; m_cow = 0;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
              if (digit(sw, i) == digit(m_secret[1-g], j)) begin
                if (i == j) m_bull++;
                else        m_cow++;
              end
          if (m_bull == 4) begin
            m_winner = (g == 1);
            m_state  = 7;
            if (g == 0) m_p1 = (m_p1 < 255) ? m_p1 + 1 : 255;
            else        m_p2 = (m_p2 < 255) ? m_p2 + 1 : 255;
          end else m_gc = 1;
        end
      end
      default: begin
        m_state = 0; m_secret[0] = '0; m_secret[1] = '0;
        m_bull = 0; m_cow = 0; m_winner = 0;
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    checkOutput({tag, ".state"},  32'(game_state),      32'(m_state));
    checkOutput({tag, ".bull"},   32'(bull_count),      32'(m_bull));
    checkOutput({tag, ".cow"},    32'(cow_count),       32'(m_cow));
    checkOutput({tag, ".gc"},     32'(guess_confirmed), 32'(m_gc));
    checkOutput({tag, ".p1"},     32'(J1_points),       32'(m_p1));
    checkOutput({tag, ".p2"},     32'(J2_points),       32'(m_p2));
    checkOutput({tag, ".winner"}, 32'(winner),          32'(m_winner));
    checkOutput({tag, ".error"},  32'(error),           32'(m_err));
  endtask

  // one button press: SW settles a full cycle before the confirm edge
  task automatic applyStimulus(input string tag, input logic [15:0] sw);
    SW = sw;
    @(posedge clock);
    @(negedge clock);
    confirm = 1'b1;
    @(posedge clock);
    #1;
    model_press(sw);
    compare_all(tag);
    @(negedge clock);
    confirm = 1'b0;
    @(posedge clock);
    #1;
    m_err = 0;
    checkOutput({tag, ".err_drop"}, 32'(error), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    model_reset();
    compare_all("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; confirm = 1'b0; SW = 16'h0000;
    model_reset();
    #2;
    compare_all("por");
    @(negedge clock);
    reset = 1'b0;

    // directed plan
    applyStimulus("bad_rep", 16'h1123);
    applyStimulus("bad_hex", 16'h12A4);
    applyStimulus("setup1",  16'h1234);
    applyStimulus("setup2",  16'h5678);
    applyStimulus("score",   16'h5687);
    applyStimulus("pass",    16'h9999);
    applyStimulus("j2_bad",  16'h1A23);
    applyStimulus("j2_win",  16'h1234);
    applyStimulus("restart", 16'h0000);

    // holding confirm produces only one press
    SW = 16'h0926;
    @(posedge clock);
    @(negedge clock);
    confirm = 1'b1;
    model_press(16'h0926);
    for (int c = 0; c < 100; c++) begin
      @(posedge clock);
      #1;
      checkOutput("hold.state", 32'(game_state), 32'(m_state));
    end
    @(negedge clock);
    confirm = 1'b0;
    @(posedge clock);

    // confirm already high at reset release is not a press
    do_reset();
    @(negedge clock);
    confirm = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("held_rst.state", 32'(game_state), 32'(0));
    @(negedge clock);
    confirm = 1'b0;

    // randomized play
    for (int k = 0; k < 400; k++) begin
      logic [15:0] sw;
      int r = int'($urandom_range(99, 0));
      if (r < 12) sw = 16'($urandom);
      else if ((m_state == 2 || m_state == 3) && r < 40) sw = m_secret[3 - m_state];
      else sw = rand_valid();
      applyStimulus("rand", sw);
    end

    // drive J1 to saturation, then one more win
    do_reset();
    while (m_p1 < 255) begin
      applyStimulus("sat_s1", 16'h1234);
      applyStimulus("sat_s2", 16'h5678);
      applyStimulus("sat_win", 16'h5678);
      applyStimulus("sat_new", 16'h0000);
    end
    applyStimulus("sat_s1", 16'h4321);
    applyStimulus("sat_s2", 16'h8765);
    applyStimulus("sat_over", 16'h8765);
    checkOutput("sat.p1", 32'(J1_points), 32'(255));
    checkOutput("sat.state", 32'(game_state), 32'(7));
    applyStimulus("sat_new", 16'h0000);

    // reset asserted mid J2_GUESS
    applyStimulus("mid_s1", 16'h1357);
    applyStimulus("mid_s2", 16'h2468);
    applyStimulus("mid_g1", 16'h2486);
    applyStimulus("mid_pass", 16'h0000);
    applyStimulus("mid_g2", 16'h3157);
    checkOutput("mid.state", 32'(game_state), 32'(3));
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    applyStimulus("post_rst", 16'h9870);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
